// File: rtl/hazard_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit: FSM encoding,
// the register-file select value and the select-width helper.
package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fsm_state_t;

  localparam int SEL_REG = 0;

  // Select must encode 0 (register file) plus one code per forwarding stage.
  function automatic int sel_width(input int num_fwd);
    return (num_fwd < 1) ? 1 : $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand priority comparator: picks the youngest producer stage whose
// destination matches this source register.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = 2
) (
  input  logic [ADDR_W-1:0]         rs,
  input  logic                      rs_use,
  input  logic [NUM_FWD*ADDR_W-1:0] dst_rd,
  input  logic [NUM_FWD-1:0]        dst_we,
  output logic [SEL_W-1:0]          sel,
  output logic                      match_ex
);

  logic [NUM_FWD-1:0] match;

  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
      assign match[gi] = rs_use & dst_we[gi]
                       & (rs == dst_rd[gi*ADDR_W +: ADDR_W])
                       & (rs != '0);
    end
  endgenerate

  // Walk from oldest to youngest so the youngest match is written last.
  always_comb begin
    sel = SEL_W'(SEL_REG);
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (match[k]) sel = SEL_W'(k + 1);
    end
  end

  assign match_ex = match[0];

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding selects with load-use stall/bubble control.
// Selects are registered; STALL/BUBBLE are combinational from state and inputs.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter  int ADDR_W     = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int NUM_FWD    = 2,
  parameter  int LOAD_STALL = 1,
  localparam int SEL_W      = sel_width(NUM_FWD)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_SRC*ADDR_W-1:0] ID_RS,
  input  logic [NUM_SRC-1:0]        ID_USE,
  input  logic [NUM_FWD*ADDR_W-1:0] DST_RD,
  input  logic [NUM_FWD-1:0]        DST_WE,
  input  logic                      EX_IS_LOAD,
  input  logic                      FLUSH,
  output logic [NUM_SRC*SEL_W-1:0]  FWD_SEL,
  output logic                      STALL,
  output logic                      BUBBLE
);

  localparam int CNT_W    = (LOAD_STALL > 2) ? $clog2(LOAD_STALL - 1) : 1;
  localparam int HOLD_CNT = (LOAD_STALL > 1) ? LOAD_STALL - 2 : 0;

  logic [NUM_SRC*SEL_W-1:0] sel_comb;
  logic [NUM_SRC-1:0]       match_ex;
  logic                     hazard;

  fsm_state_t               state_reg, state_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_reg, fwd_sel_next;
  logic                     stall;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_select #(
        .ADDR_W  (ADDR_W),
        .NUM_FWD (NUM_FWD),
        .SEL_W   (SEL_W)
      ) u_fwd_select (
        .rs       (ID_RS[gi*ADDR_W +: ADDR_W]),
        .rs_use   (ID_USE[gi]),
        .dst_rd   (DST_RD),
        .dst_we   (DST_WE),
        .sel      (sel_comb[gi*SEL_W +: SEL_W]),
        .match_ex (match_ex[gi])
      );
    end
  endgenerate

  assign hazard = EX_IS_LOAD & DST_WE[0] & (|match_ex);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    fwd_sel_next = '0;
    stall        = 1'b0;
    case (state_reg)
      RUN: begin
        if (FLUSH) begin
          stall = 1'b0;
        end else if (hazard) begin
          stall = 1'b1;
          if (LOAD_STALL > 1) begin
            state_next = HOLD;
            cnt_next   = CNT_W'(HOLD_CNT);
          end
        end else begin
          fwd_sel_next = sel_comb;
        end
      end
      HOLD: begin
        if (FLUSH) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          stall = 1'b1;
          if (cnt_reg == '0) state_next = RUN;
          else               cnt_next   = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
    // Reset must not hold the front end, even while the FSM is mid-count.
    if (RESET) stall = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= RUN;
      cnt_reg     <= '0;
      fwd_sel_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      fwd_sel_reg <= fwd_sel_next;
    end
  end

  assign FWD_SEL = fwd_sel_reg;
  assign STALL   = stall;
  assign BUBBLE  = stall;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: two configurations driven from shared stimulus, each checked
// against a remaining-stall-cycles reference model.
module tb_hazard_forward_unit;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic [5:0] rs [3];
  logic [5:0] rd [3];
  logic [2:0] use_v;
  logic [2:0] we;
  logic       is_load;
  logic       flush;

  // Config A: defaults (5-bit addr, 2 operands, 2 stages, 1 bubble)
  logic [3:0] sel_a;
  logic       stall_a, bubble_a;
  // Config B: 6-bit addr, 3 operands, 3 stages, 3 bubbles
  logic [5:0] sel_b;
  logic       stall_b, bubble_b;

  hazard_forward_unit u_dut_a (
    .CLK        (CLK),
    .RESET      (RESET),
    .ID_RS      ({rs[1][4:0], rs[0][4:0]}),
    .ID_USE     (use_v[1:0]),
    .DST_RD     ({rd[1][4:0], rd[0][4:0]}),
    .DST_WE     (we[1:0]),
    .EX_IS_LOAD (is_load),
    .FLUSH      (flush),
    .FWD_SEL    (sel_a),
    .STALL      (stall_a),
    .BUBBLE     (bubble_a)
  );

  hazard_forward_unit #(
    .ADDR_W     (6),
    .NUM_SRC    (3),
    .NUM_FWD    (3),
    .LOAD_STALL (3)
  ) u_dut_b (
    .CLK        (CLK),
    .RESET      (RESET),
    .ID_RS      ({rs[2], rs[1], rs[0]}),
    .ID_USE     (use_v),
    .DST_RD     ({rd[2], rd[1], rd[0]}),
    .DST_WE     (we),
    .EX_IS_LOAD (is_load),
    .FLUSH      (flush),
    .FWD_SEL    (sel_b),
    .STALL      (stall_b),
    .BUBBLE     (bubble_b)
  );

  typedef struct packed {
    logic       chk_sel;
    logic       stall_a;
    logic       stall_b;
    logic [3:0] sel_a;
    logic [5:0] sel_b;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 0;

  // Model state: cycles of stall still owed, and the select currently presented.
  int         left  [2] = '{0, 0};
  logic [5:0] msel  [2] = '{6'd0, 6'd0};
  bit         known = 0;

  function automatic bit match(input int i, input int k);
    return use_v[i] && we[k] && (rs[i] == rd[k]) && (rs[i] != 0);
  endfunction

  task automatic model_step(input int id, input int ns, input int nf, input int ls,
                            output logic stall_e, output logic [5:0] sel_vis);
    logic [5:0] nsel;
    bit         hz;
    int         s;
    sel_vis = msel[id];
    nsel    = '0;
    hz      = 0;
    for (int i = 0; i < ns; i++) begin
      s = 0;
      for (int k = 0; k < nf; k++) if (s == 0 && match(i, k)) s = k + 1;
      nsel[i*2 +: 2] = s[1:0];
      if (is_load && we[0] && match(i, 0)) hz = 1;
    end
    stall_e = 0;
    if (RESET) begin
      left[id] = 0;
      msel[id] = '0;
    end else if (left[id] > 0) begin
      if (flush) left[id] = 0;
      else begin
        stall_e  = 1;
        left[id] = left[id] - 1;
      end
      msel[id] = '0;
    end else if (flush) begin
      msel[id] = '0;
    end else if (hz) begin
      stall_e  = 1;
      left[id] = ls - 1;
      msel[id] = '0;
    end else begin
      msel[id] = nsel;
    end
  endtask

  task automatic issue(input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2,
                       input logic [2:0] u, input logic [5:0] d0, input logic [5:0] d1,
                       input logic [5:0] d2, input logic [2:0] w, input logic ld,
                       input logic fl, input logic rst);
    exp_t       e;
    logic       st;
    logic [5:0] sv;
    @(posedge CLK);
    #1;
    rs[0] = r0; rs[1] = r1; rs[2] = r2; use_v = u;
    rd[0] = d0; rd[1] = d1; rd[2] = d2; we = w;
    is_load = ld; flush = fl; RESET = rst;
    e.chk_sel = known;
    model_step(0, 2, 2, 1, st, sv);
    e.stall_a = st;
    e.sel_a   = sv[3:0];
    model_step(1, 3, 3, 3, st, sv);
    e.stall_b = st;
    e.sel_b   = sv;
    if (rst) known = 1;
    sbq.push_back(e);
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("stall_a",  {5'd0, stall_a},  {5'd0, e.stall_a});
        check("bubble_a", {5'd0, bubble_a}, {5'd0, e.stall_a});
        check("stall_b",  {5'd0, stall_b},  {5'd0, e.stall_b});
        check("bubble_b", {5'd0, bubble_b}, {5'd0, e.stall_b});
        if (e.chk_sel) begin
          check("fwd_sel_a", {2'd0, sel_a}, {2'd0, e.sel_a});
          check("fwd_sel_b", sel_b, e.sel_b);
        end
        $display("cyc t=%0t rst=%0b ld=%0b fl=%0b stall_a=%0b sel_a=%0h stall_b=%0b sel_b=%0h",
                 $time, RESET, is_load, flush, stall_a, sel_a, stall_b, sel_b);
      end
    end
  end

  initial begin
    RESET = 1'b1; flush = 0; is_load = 0; use_v = 0; we = 0;
    for (int i = 0; i < 3; i++) begin rs[i] = 0; rd[i] = 0; end

    issue(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 1);
    issue(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 1);
    // op0=x1 forwarded from EX, op1=x2 from register file
    issue(1, 2, 0, 3'b011, 1, 0, 0, 3'b001, 0, 0, 0);
    // youngest producer wins, then older, then x0 never forwards
    issue(3, 0, 0, 3'b001, 3, 3, 0, 3'b011, 0, 0, 0);
    issue(3, 0, 0, 3'b001, 3, 3, 0, 3'b010, 0, 0, 0);
    issue(0, 0, 0, 3'b001, 0, 0, 0, 3'b011, 0, 0, 0);
    // op2 matches stage 1 on the wide config
    issue(0, 0, 4, 3'b100, 0, 4, 0, 3'b010, 0, 0, 0);
    issue(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0);
    // load-use on x5, then the load has moved to MEM
    issue(5, 0, 0, 3'b001, 5, 0, 0, 3'b001, 1, 0, 0);
    issue(5, 0, 0, 3'b001, 0, 5, 0, 3'b010, 0, 0, 0);
    issue(5, 0, 0, 3'b001, 0, 0, 5, 3'b100, 0, 0, 0);
    issue(5, 0, 0, 3'b001, 0, 0, 0, 3'b000, 0, 0, 0);
    issue(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0);
    // hazard then flush on the second stall cycle
    issue(6, 0, 0, 3'b001, 6, 0, 0, 3'b001, 1, 0, 0);
    issue(6, 0, 0, 3'b001, 0, 6, 0, 3'b010, 0, 1, 0);
    issue(6, 0, 0, 3'b001, 0, 6, 0, 3'b010, 0, 0, 0);
    // flush and hazard together: flush wins
    issue(7, 0, 0, 3'b001, 7, 0, 0, 3'b001, 1, 1, 0);
    // reset aborts HOLD
    issue(7, 0, 0, 3'b001, 7, 0, 0, 3'b001, 1, 0, 0);
    issue(7, 0, 0, 3'b001, 0, 7, 0, 3'b010, 0, 0, 0);
    issue(7, 0, 0, 3'b001, 0, 7, 0, 3'b010, 0, 0, 1);
    issue(7, 0, 0, 3'b001, 0, 7, 0, 3'b010, 0, 0, 0);
    // matching address but operand unused
    issue(2, 0, 0, 3'b000, 2, 0, 0, 3'b001, 1, 0, 0);

    for (int n = 0; n < 2000; n++) begin
      issue(6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            3'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            6'($urandom_range(0, 7)), 3'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 49) == 0));
    end
    stim_done = 1;
  end

  initial begin
    wait (stim_done);
    for (int c = 0; c < 10 && sbq.size() > 0; c++) @(posedge CLK);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
